moore_sched: RTL and testbench
==============================

MOORE_SCHED -- requirements
Module: moore_sched

Interface
REQ-001 Parameter NCH, default 4, number of serial input channels sharing one detector engine (2..8).
REQ-002 Parameter CW, default 8, width of each per-channel match counter.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NCH  per-channel "bit available" request.
REQ-006 bit_in  input  NCH  per-channel serial data bit, valid when matching req is high.
REQ-007 clr  input  1  synchronous clear of all match counters.
REQ-008 grant  output  NCH  one-hot, combinational, marks the channel whose bit is consumed at the next rising edge.
REQ-009 found  output  NCH  per-channel Moore output, high while that channel's context is in S1101.
REQ-010 count  output  NCH*CW  packed per-channel match counters, channel i at bits [i*CW +: CW].

Function
REQ-011 The block SHALL hold one 3-bit detector context per channel: START=000, S1=001, S11=011, S110=010, S1101=110.
REQ-012 The next-state rules SHALL be:
- START: 1->S1, 0->START.
- S1: 1->S11, 0->START.
- S11: 1->S11, 0->S110.
- S110: 1->S1101, 0->START.
- S1101: 1->S11, 0->START.
- Any other code: ->START.
REQ-013 Arbitration SHALL be round-robin: search starts at channel ptr+1 mod NCH, and grant goes to the first channel with req high.
REQ-014 With no req high, grant SHALL be all-zero, and ptr and all contexts SHALL hold.
REQ-015 At a rising edge with grant[i] high, context i SHALL advance per REQ-012 using bit_in[i], and ptr SHALL become i.
REQ-016 Only the granted context SHALL change in a cycle; ungranted channels' bits are not consumed, and their requesters hold req and bit_in until granted.
REQ-017 found[i] SHALL equal context_i[2] (registered Moore output) and SHALL assert the cycle after the edge that consumed the completing bit.
REQ-018 found[i] SHALL stay high until channel i's next bit is consumed.
REQ-019 Overlapping patterns SHALL be detected: 1101101 on one channel yields two matches.
REQ-020 Any starvation-free bound SHALL hold: a continuously requesting channel is granted within NCH cycles.

Reset
REQ-021 While reset is low:
- all contexts = START;
- ptr = NCH-1, so channel 0 has first priority;
- found = 0;
- count = 0;
- grant = 0 regardless of req.
REQ-022 Reset asserted mid-stream SHALL discard all partial matches immediately (asynchronously); the first edge after release is treated as a fresh start.
REQ-023 clr SHALL have no effect on contexts or ptr.

Configuration
REQ-024 Macro MOORE_SCHED_COUNT_EN defined: each context entry into S1101 increments that channel's counter by 1.
REQ-025 The counter SHALL saturate at 2^CW-1.
REQ-026 If clr and an increment coincide on the same edge, clr SHALL win and the counter SHALL become 0.
REQ-027 Macro MOORE_SCHED_COUNT_EN undefined: no counter registers exist, count is tied to 0, clr is ignored, and all other behaviour is unchanged.

Structure
REQ-028 Package moore_sched_pkg SHALL hold the five state encodings, the state-vector typedef (3 bits), and the default NCH/CW values.
REQ-029 Sub-module moore_step (purely combinational: state, x -> next_state, match) SHALL implement REQ-012 and be instantiated once.
REQ-030 The arbiter, context array, and counters SHALL live in moore_sched.

Verification
REQ-031 Reset, then req=0001, bit_in[0] serial 1,1,0,1 over four grants -> found[0]=1 one cycle after the fourth edge; count[0]=1.
REQ-032 req=1111 held for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,... with no skips.
REQ-033 Channel 2 serial 1,1,0,1,1,0,1 (others idle) -> found[2] pulses twice; count[2]=2; S1101->S11 overlap verified.
REQ-034 Channel 1 fed 1,1,0, then reset pulsed low, then 1 -> found[1]=0 and context[1]=S1 (no stale S110).
REQ-035 CW=2, channel 0 fed 1101 five times -> count[0] stops at 3; clr coincident with the 6th match -> count[0]=0.
REQ-036 Build without MOORE_SCHED_COUNT_EN, rerun REQ-031 -> found identical, count=0 throughout.

Source files
------------

// File: rtl/moore_sched_pkg.sv
// rtl/moore_sched_pkg.sv - shared state encodings and default sizes for moore_sched
package moore_sched_pkg;

    // Detector context encoding; S1101 is the only state with bit 2 set
    typedef enum logic [2:0] {
        START = 3'b000,
        S1    = 3'b001,
        S11   = 3'b011,
        S110  = 3'b010,
        S1101 = 3'b110
    } state_t;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 8;

endpackage

// File: rtl/moore_step.sv
// rtl/moore_step.sv - combinational next-state step of the 1101 detector
module moore_step
    import moore_sched_pkg::*;
(
    input  state_t state,
    input  logic   x,
    output state_t next_state,
    output logic   match
);

    // Overlapping 1101 transition table; unknown codes fall back to START
    always_comb begin
        next_state = START;
        case (state)
            START:   next_state = x ? S1    : START;
            S1:      next_state = x ? S11   : START;
            S11:     next_state = x ? S11   : S110;
            S110:    next_state = x ? S1101 : START;
            S1101:   next_state = x ? S11   : START;
            default: next_state = START;
        endcase
        match = (next_state == S1101);
    end

endmodule

// File: rtl/moore_sched.sv
// rtl/moore_sched.sv - round-robin shared 1101 detector engine; optional counters via MOORE_SCHED_COUNT_EN
module moore_sched
    import moore_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    bit_in,
    input  logic              clr,
    output logic [NCH-1:0]    grant,
    output logic [NCH-1:0]    found,
    output logic [NCH*CW-1:0] count
);

    localparam int PW = $clog2(NCH);

    state_t          ctx [NCH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            hit;
    state_t          step_state;
    state_t          step_next;
    logic            step_bit;
    logic            step_match;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        int idx;
        idx   = 0;
        hit   = 1'b0;
        gidx  = '0;
        grant = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!hit && req[idx]) begin
                hit  = 1'b1;
                gidx = PW'(idx);
            end
        end
        if (hit && reset) begin
            grant[gidx] = 1'b1;
        end
    end

    // The single shared engine sees only the granted channel's context and bit
    always_comb begin
        step_state = ctx[gidx];
        step_bit   = bit_in[gidx];
    end

    moore_step u_step (
        .state      (step_state),
        .x          (step_bit),
        .next_state (step_next),
        .match      (step_match)
    );

    // Context array and pointer: only the granted channel advances
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx[i] <= START;
            end
            ptr <= PW'(NCH - 1);
        end else if (hit) begin
            ctx[gidx] <= step_next;
            ptr       <= gidx;
        end
    end

    // Moore output taken straight from each context register
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            found[i] = ctx[i][2];
        end
    end

`ifdef MOORE_SCHED_COUNT_EN
    logic [CW-1:0] cnt [NCH];

    // Saturating per-channel match counters; clr beats a same-edge increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr) begin
                    cnt[i] <= '0;
                end else if (grant[i] && step_match && (cnt[i] != {CW{1'b1}})) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pack counters onto the flat count bus
    always_comb begin
        count = '0;
        for (int i = 0; i < NCH; i++) begin
            count[i*CW +: CW] = cnt[i];
        end
    end
`else
    logic unused_sig;

    assign unused_sig = clr ^ step_match;
    assign count      = '0;
`endif

endmodule

// File: tb/tb_moore_sched.sv
// tb/tb_moore_sched.sv - directed self-checking bench for moore_sched
module tb_moore_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic              clock;
    logic              reset;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    bit_in;
    logic              clr;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    found;
    logic [NCH*CW-1:0] count;

    int checks;
    int fails;

`ifdef MOORE_SCHED_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    moore_sched #(.NCH(NCH), .CW(CW)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .bit_in (bit_in),
        .clr    (clr),
        .grant  (grant),
        .found  (found),
        .count  (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*CW-1:0] exp_count(input int ch, input int n);
        logic [NCH*CW-1:0] v;
        v = '0;
        if (CNT_ON) v[ch*CW +: CW] = CW'(n);
        return v;
    endfunction

    // One bit on one channel, all others idle; checks the grant and consumes one edge
    task automatic feed(input int ch, input logic b, input string tag);
        logic [NCH-1:0] g;
        g = '0;
        g[ch] = 1'b1;
        req = g;
        bit_in = b ? g : '0;
        #1;
        check({tag, "_grant"}, 32'(grant), 32'(g));
        @(posedge clock);
        #1;
        req = '0;
        bit_in = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [NCH-1:0] exp_g;
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        req    = 4'b1111;
        bit_in = '0;
        clr    = 1'b0;

        // Reset state: grant forced low even with all requests up
        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_found", 32'(found), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        #1;

        // Channel 0 fed 1101
        feed(0, 1'b1, "a1");
        feed(0, 1'b1, "a2");
        feed(0, 1'b0, "a3");
        check("a3_found", 32'(found), 32'h0);
        feed(0, 1'b1, "a4");
        check("a4_found", 32'(found), 32'b0001);
        check("a4_count", 32'(count), 32'(exp_count(0, 1)));

        // Round robin over all four requesters after reset
        pulse_reset();
        req = 4'b1111;
        bit_in = '0;
        for (int c = 0; c < 8; c++) begin
            exp_g = 4'b0001 << (c % 4);
            #1;
            check($sformatf("rr_%0d", c), 32'(grant), 32'(exp_g));
            @(posedge clock);
            #1;
        end
        // Idle cycle must keep the pointer at channel 3
        req = '0;
        #1;
        check("idle_grant", 32'(grant), 32'h0);
        @(posedge clock);
        #1;
        req = 4'b1010;
        #1;
        check("hold_ptr", 32'(grant), 32'b0010);
        req = '0;
        @(negedge clock);

        // Channel 2 overlapping 1101101
        pulse_reset();
        feed(2, 1'b1, "b1");
        feed(2, 1'b1, "b2");
        feed(2, 1'b0, "b3");
        feed(2, 1'b1, "b4");
        check("b4_found", 32'(found), 32'b0100);
        feed(0, 1'b1, "b_other");
        check("b_hold", 32'(found), 32'b0100);
        feed(2, 1'b1, "b5");
        check("b5_found", 32'(found), 32'h0);
        feed(2, 1'b0, "b6");
        feed(2, 1'b1, "b7");
        check("b7_found", 32'(found), 32'b0100);
        check("b7_count", 32'(count), 32'(exp_count(2, 2)));

        // Channel 1 partial match wiped by an asynchronous reset
        pulse_reset();
        feed(1, 1'b1, "c1");
        feed(1, 1'b1, "c2");
        feed(1, 1'b0, "c3");
        #2;
        reset = 1'b0;
        #1;
        check("c_rst_found", 32'(found), 32'h0);
        req = 4'b0010;
        #1;
        check("c_rst_grant", 32'(grant), 32'h0);
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        feed(1, 1'b1, "c4");
        check("c4_found", 32'(found), 32'h0);
        feed(1, 1'b1, "c5");
        feed(1, 1'b0, "c6");
        feed(1, 1'b1, "c7");
        check("c7_found", 32'(found), 32'b0010);

        // Saturation of the 2-bit counter, then clr colliding with a match
        pulse_reset();
        for (int r = 1; r <= 5; r++) begin
            feed(0, 1'b1, "d");
            feed(0, 1'b1, "d");
            feed(0, 1'b0, "d");
            feed(0, 1'b1, "d");
            check($sformatf("d_count_%0d", r), 32'(count), 32'(exp_count(0, (r > 3) ? 3 : r)));
        end
        feed(0, 1'b1, "e1");
        feed(0, 1'b1, "e2");
        feed(0, 1'b0, "e3");
        clr = 1'b1;
        feed(0, 1'b1, "e4");
        clr = 1'b0;
        check("e4_count", 32'(count), 32'h0);
        check("e4_found", 32'(found), 32'b0001);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
